// File: rtl/simplez_cpu.sv
// -----------------------------------------------------------------------------
// simplez_cpu -- multicycle Simplez processor core (control unit + datapath).
//
// Drives a 512x12 program/data memory that captures on the falling clock edge,
// so a read issued in one cycle is sampled by the core on the next rising edge,
// and a write commits at the mid-cycle falling edge of the WRITE cycle.
//
// Instruction word: opcode = [11:9], CD (operand address) = [8:0].
//   0 ST   1 LD   2 ADD  3 BR   4 BZ   5 CLR  6 DEC  7 HALT
// Cycles FETCH->FETCH: ST/BR/BZ/CLR/DEC/HALT = 3, LD/ADD = 4.
//
// Ports:
//   clk       in   system clock, all state changes on posedge
//   rst       in   asynchronous, active-high reset
//   step      in   (only with SIMPLEZ_STEP_EN) advance out of FETCH when high
//   mem_addr  out  memory address (PC, or CD during READ/WRITE)
//   mem_rd    out  memory read enable
//   mem_wr    out  memory write enable
//   mem_dout  out  write data, always the accumulator
//   mem_din   in   read data; only sampled in DECODE and WB
//   halted    out  core has executed HALT
//   acc       out  accumulator A (debug)
//   zflag     out  Z flag
//
// Optional feature: define SIMPLEZ_STEP_EN to add the single-step input.
// -----------------------------------------------------------------------------
module simplez_cpu #(
  parameter int              AW       = 9,
  parameter int              DW       = 12,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
`ifdef SIMPLEZ_STEP_EN
  input  logic          step,
`endif
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_dout,
  input  logic [DW-1:0] mem_din,
  output logic          halted,
  output logic [DW-1:0] acc,
  output logic          zflag
);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_READ, S_WB, S_WRITE, S_HALTED
  } state_e;

  typedef enum logic [2:0] {
    OP_ST, OP_LD, OP_ADD, OP_BR, OP_BZ, OP_CLR, OP_DEC, OP_HALT
  } opcode_e;

  localparam logic [AW-1:0] ONE_A = AW'(1);
  localparam logic [DW-1:0] ONE_D = DW'(1);

  state_e        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [DW-1:0] ir_q, ir_d;
  logic [DW-1:0] a_q, a_d;
  logic          z_q, z_d;

  opcode_e       ir_op, din_op;
  logic [AW-1:0] cd;
  logic [DW-1:0] dec_res, wb_res;
  logic          advance;

  assign ir_op   = opcode_e'(ir_q[DW-1 -: 3]);
  assign din_op  = opcode_e'(mem_din[DW-1 -: 3]);
  assign cd      = ir_q[AW-1:0];
  assign dec_res = a_q - ONE_D;
  // WB serves both LD and ADD; the carry out of ADD is simply dropped.
  assign wb_res  = (ir_op == OP_ADD) ? (a_q + mem_din) : mem_din;

`ifdef SIMPLEZ_STEP_EN
  assign advance = step;
`else
  assign advance = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      z_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      z_q     <= z_d;
    end
  end

  // Bus outputs decode from state_q only, so reset forces them to the FETCH
  // pattern (rd=1, wr=0) asynchronously and an in-flight write is abandoned.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    a_d      = a_q;
    z_d      = z_q;
    mem_addr = pc_q;
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_rd = 1'b1;
        if (advance) state_d = S_DECODE;
      end
      S_DECODE: begin
        // The opcode is dispatched straight from the incoming word so the
        // third cycle is already the opcode-specific one.
        ir_d = mem_din;
        pc_d = pc_q + ONE_A;
        case (din_op)
          OP_ST:          state_d = S_WRITE;
          OP_LD, OP_ADD:  state_d = S_READ;
          default:        state_d = S_EXEC;
        endcase
      end
      S_EXEC: begin
        state_d = S_FETCH;
        case (ir_op)
          OP_BR:   pc_d = cd;
          OP_BZ:   if (z_q) pc_d = cd;
          OP_CLR: begin
            a_d = '0;
            z_d = 1'b1;
          end
          OP_DEC: begin
            a_d = dec_res;
            z_d = (dec_res == '0);
          end
          OP_HALT: state_d = S_HALTED;
          default: ;
        endcase
      end
      S_READ: begin
        mem_addr = cd;
        mem_rd   = 1'b1;
        state_d  = S_WB;
      end
      S_WB: begin
        a_d     = wb_res;
        z_d     = (wb_res == '0);
        state_d = S_FETCH;
      end
      S_WRITE: begin
        mem_addr = cd;
        mem_wr   = 1'b1;
        state_d  = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_FETCH;
    endcase
  end

  assign mem_dout = a_q;
  assign halted   = (state_q == S_HALTED);
  assign acc      = a_q;
  assign zflag    = z_q;

endmodule

// File: tb/tb_simplez_cpu.sv
// -----------------------------------------------------------------------------
// tb_simplez_cpu -- self-checking bench for simplez_cpu.
// Contains a 512x12 negedge-capturing memory, a table of single-instruction
// vectors, directed multi-cycle sequences, and random programs checked against
// an instruction-level reference model.
// -----------------------------------------------------------------------------
module tb_simplez_cpu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  mem_addr;
  logic        mem_rd, mem_wr, halted, zflag;
  logic [11:0] mem_dout, acc;
  wire  [11:0] mem_din;
`ifdef SIMPLEZ_STEP_EN
  logic        step = 1'b1;
`endif

  simplez_cpu dut (
    .clk      (clk),
    .rst      (rst),
`ifdef SIMPLEZ_STEP_EN
    .step     (step),
`endif
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .mem_wr   (mem_wr),
    .mem_dout (mem_dout),
    .mem_din  (mem_din),
    .halted   (halted),
    .acc      (acc),
    .zflag    (zflag)
  );

  always #5 clk = ~clk;

  // ---------------- memory: captures on negedge, output valid for the cycle
  // following a read cycle, high-Z otherwise.
  logic [11:0] ram [512];
  logic [11:0] rdata = '0;
  logic        rvalid;
  logic        saw5 = 1'b0, saw_wr = 1'b0;

  always @(negedge clk) begin
    if (mem_wr) ram[mem_addr] = mem_dout;
    if (mem_rd) rdata <= ram[mem_addr];
    if (mem_addr == 9'd5) saw5 = 1'b1;
    if (mem_wr) saw_wr = 1'b1;
  end

  always @(posedge clk or posedge rst)
    if (rst) rvalid <= 1'b0;
    else     rvalid <= mem_rd;

  assign mem_din = rvalid ? rdata : 12'bz;

  // ---------------- checking
  int n_vec = 0, n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0o, expected %0o", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bus(input logic h, input logic z, input logic rd,
                                      input logic wr, input logic [8:0] ad, input logic [11:0] a);
    return {7'd0, h, z, rd, wr, ad, a};
  endfunction

  function automatic logic [31:0] dut_bus();
    return bus(halted, zflag, mem_rd, mem_wr, mem_addr, acc);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 512; i++) ram[i] = '0;
  endtask

  task automatic load_add_prog();
    clear_ram();
    ram[0] = 12'o1004; ram[1] = 12'o2005; ram[2] = 12'o0006; ram[3] = 12'o7000;
    ram[4] = 12'o0004; ram[5] = 12'o0005; ram[6] = 12'o1234;
  endtask

  // Counts posedges until halted rises; bounded.
  task automatic run_to_halt(output int cyc);
    cyc = 0;
    while (!halted && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // ---------------- table of single-instruction vectors
  // Program: 0: LD /012 (A<=a_init), 1: instr, 2: HALT, 3: DEC, 4: HALT,
  // 012: a_init, 013: operand. Branches target 3.
  typedef struct {
    string       name;
    logic [11:0] a_init, operand, instr, exp_acc;
    logic        exp_z;
    int          exp_cyc;
    logic [11:0] exp_m11;
  } vec_t;

  function automatic vec_t mk(input string n, input logic [11:0] ai, input logic [11:0] op,
                              input logic [11:0] in, input logic [11:0] ea, input logic ez,
                              input int ec, input logic [11:0] em);
    vec_t v;
    v.name = n; v.a_init = ai; v.operand = op; v.instr = in; v.exp_acc = ea;
    v.exp_z = ez; v.exp_cyc = ec; v.exp_m11 = em;
    return v;
  endfunction

  // ---------------- reference model (instruction level)
  int m_pc, m_a, m_halt;
  bit m_z;
  int mm [512];

  task automatic model_step(output int len);
    int w, op, cd;
    w  = mm[m_pc];
    op = w / 512;
    cd = w % 512;
    m_pc = (m_pc + 1) % 512;
    len = 3;
    case (op)
      0: mm[cd] = m_a;
      1: begin m_a = mm[cd]; m_z = (m_a == 0); len = 4; end
      2: begin m_a = (m_a + mm[cd]) % 4096; m_z = (m_a == 0); len = 4; end
      3: m_pc = cd;
      4: if (m_z) m_pc = cd;
      5: begin m_a = 0; m_z = 1; end
      6: begin m_a = (m_a + 4095) % 4096; m_z = (m_a == 0); end
      default: m_halt = 1;
    endcase
  endtask

  // ---------------- test sequence
  initial begin
    vec_t tbl[11];
    int   cyc;
    logic [11:0] a_hold;
    logic [8:0]  ad_hold;
    bit   hold_ok;

    tbl[0]  = mk("add_wrap",  12'o7777, 12'o0001, 12'o2013, 12'o0000, 1'b1, 11, 12'o0001);
    tbl[1]  = mk("add",       12'o0004, 12'o0005, 12'o2013, 12'o0011, 1'b0, 11, 12'o0005);
    tbl[2]  = mk("ld_zero",   12'o0123, 12'o0000, 12'o1013, 12'o0000, 1'b1, 11, 12'o0000);
    tbl[3]  = mk("st",        12'o0456, 12'o1111, 12'o0013, 12'o0456, 1'b0, 10, 12'o0456);
    tbl[4]  = mk("dec_to_0",  12'o0001, 12'o0000, 12'o6000, 12'o0000, 1'b1, 10, 12'o0000);
    tbl[5]  = mk("dec_from0", 12'o0000, 12'o0000, 12'o6000, 12'o7777, 1'b0, 10, 12'o0000);
    tbl[6]  = mk("clr",       12'o0567, 12'o0003, 12'o5000, 12'o0000, 1'b1, 10, 12'o0003);
    tbl[7]  = mk("bz_taken",  12'o0000, 12'o0000, 12'o4003, 12'o7777, 1'b0, 13, 12'o0000);
    tbl[8]  = mk("bz_not",    12'o0005, 12'o0000, 12'o4003, 12'o0005, 1'b0, 10, 12'o0000);
    tbl[9]  = mk("br",        12'o0001, 12'o0000, 12'o3003, 12'o0000, 1'b1, 13, 12'o0000);
    tbl[10] = mk("halt",      12'o0042, 12'o0077, 12'o7000, 12'o0042, 1'b0, 7,  12'o0077);

    // Reset state
    clear_ram();
    do_reset();
    check("reset_bus", dut_bus(), bus(1'b0, 1'b1, 1'b1, 1'b0, 9'd0, 12'o0000));

    // ---- table-driven vectors
    for (int i = 0; i < 11; i++) begin
      clear_ram();
      ram[0] = 12'o1012; ram[1] = tbl[i].instr; ram[2] = 12'o7000;
      ram[3] = 12'o6000; ram[4] = 12'o7000;
      ram[10] = tbl[i].a_init; ram[11] = tbl[i].operand;
      do_reset();
      run_to_halt(cyc);
      check({tbl[i].name, "_acc_z"}, {19'd0, zflag, acc}, {19'd0, tbl[i].exp_z, tbl[i].exp_acc});
      check({tbl[i].name, "_cycles"}, cyc, tbl[i].exp_cyc);
      check({tbl[i].name, "_mem013"}, {20'd0, ram[11]}, {20'd0, tbl[i].exp_m11});
    end

    // ---- add program: 14 cycles, mem[6]=o0011
    load_add_prog();
    do_reset();
    run_to_halt(cyc);
    check("addprog_cycles", cyc, 14);
    check("addprog_bus", dut_bus(), bus(1'b1, 1'b0, 1'b0, 1'b0, 9'd4, 12'o0011));
    check("addprog_mem6", {20'd0, ram[6]}, {20'd0, 12'o0011});

    // ---- halt hold: 50 cycles frozen
    a_hold = acc; ad_hold = mem_addr; hold_ok = 1'b1;
    for (int i = 0; i < 50; i++) begin
      cycles(1);
      if (mem_rd || mem_wr || !halted || acc != a_hold || mem_addr != ad_hold) hold_ok = 1'b0;
    end
    check("halt_hold", {31'd0, hold_ok}, 32'd1);

    // ---- decrement from zero; BZ not taken, mem[5] never addressed
    clear_ram();
    ram[0] = 12'o5000; ram[1] = 12'o6000; ram[2] = 12'o4005; ram[3] = 12'o7000;
    ram[5] = 12'o5000;
    do_reset();
    saw5 = 1'b0;
    run_to_halt(cyc);
    check("decz_cycles", cyc, 12);
    check("decz_bus", dut_bus(), bus(1'b1, 1'b0, 1'b0, 1'b0, 9'd4, 12'o7777));
    check("decz_no_addr5", {31'd0, saw5}, 32'd0);

    // ---- branch and wrap
    clear_ram();
    ram[0] = 12'o3777; ram[511] = 12'o6000;
    do_reset();
    check("wrap_f0", dut_bus(), bus(1'b0, 1'b1, 1'b1, 1'b0, 9'd0, 12'o0000));
    cycles(3);
    check("wrap_f1", dut_bus(), bus(1'b0, 1'b1, 1'b1, 1'b0, 9'd511, 12'o0000));
    cycles(3);
    check("wrap_f2", dut_bus(), bus(1'b0, 1'b0, 1'b1, 1'b0, 9'd0, 12'o7777));
    cycles(3);
    check("wrap_f3", dut_bus(), bus(1'b0, 1'b0, 1'b1, 1'b0, 9'd511, 12'o7777));
    cycles(3);
    check("wrap_f4", dut_bus(), bus(1'b0, 1'b0, 1'b1, 1'b0, 9'd0, 12'o7776));

    // ---- reset in the middle of the ST WRITE cycle
    load_add_prog();
    do_reset();
    cycles(8);   // FETCH of ST
    cycles(2);   // now in WRITE, before its negedge
    check("midwr_write", dut_bus(), bus(1'b0, 1'b0, 1'b0, 1'b1, 9'd6, 12'o0011));
    rst = 1'b1;
    #1;
    check("midwr_rst_bus", dut_bus(), bus(1'b0, 1'b1, 1'b1, 1'b0, 9'd0, 12'o0000));
    @(negedge clk);
    #1;
    check("midwr_mem6", {20'd0, ram[6]}, {20'd0, 12'o1234});
    rst = 1'b0;
    check("midwr_fetch0", dut_bus(), bus(1'b0, 1'b1, 1'b1, 1'b0, 9'd0, 12'o0000));
    cycles(4);
    check("midwr_ld", dut_bus(), bus(1'b0, 1'b0, 1'b1, 1'b0, 9'd1, 12'o0004));

    // ---- random programs against the reference model
    for (int p = 0; p < 8; p++) begin
      int len, diffs;
      for (int i = 0; i < 512; i++) begin
        logic [11:0] w;
        w = 12'($urandom_range(0, 4095));
        if ($urandom_range(0, 7) == 0) w = '0;
        if (w[11:9] == 3'd7 && $urandom_range(0, 3) != 0) w[11:9] = 3'($urandom_range(0, 6));
        ram[i] = w;
        mm[i]  = int'(w);
      end
      m_pc = 0; m_a = 0; m_z = 1'b1; m_halt = 0;
      do_reset();
      check("rnd_start", dut_bus(), bus(1'b0, 1'b1, 1'b1, 1'b0, 9'd0, 12'o0000));
      for (int k = 0; k < 60 && m_halt == 0; k++) begin
        model_step(len);
        cycles(len);
        check($sformatf("rnd%0d_i%0d", p, k), dut_bus(),
              bus(m_halt != 0, m_z, m_halt == 0, 1'b0, 9'(m_pc), 12'(m_a)));
      end
      diffs = 0;
      for (int i = 0; i < 512; i++) if (ram[i] != 12'(mm[i])) diffs++;
      check($sformatf("rnd%0d_ram", p), diffs, 0);
    end

`ifdef SIMPLEZ_STEP_EN
    // ---- single step: two pulses 10 cycles apart run exactly LD and ADD
    load_add_prog();
    step = 1'b0;
    do_reset();
    saw_wr = 1'b0;
    cycles(5);
    check("step_wait", dut_bus(), bus(1'b0, 1'b1, 1'b1, 1'b0, 9'd0, 12'o0000));
    for (int n = 0; n < 2; n++) begin
      @(negedge clk); step = 1'b1;
      @(negedge clk); step = 1'b0;
      repeat (8) @(negedge clk);
      #1;
      check($sformatf("step_pulse%0d", n), dut_bus(),
            (n == 0) ? bus(1'b0, 1'b0, 1'b1, 1'b0, 9'd1, 12'o0004)
                     : bus(1'b0, 1'b0, 1'b1, 1'b0, 9'd2, 12'o0011));
    end
    check("step_no_write", {31'd0, saw_wr}, 32'd0);
    step = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
